rgb2raw: RTL and testbench

RGB2RAW -- requirements
Module: rgb2raw

---
 rtl/top_pkg.sv | 20 ++
 rtl/rgb2raw.sv | 151 +++++++++++++++
 tb/tb_rgb2raw.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/top_pkg.sv
// rtl/top_pkg.sv - shared lane types plus the rgb2raw pixel struct and state encoding
package top_pkg;

  // One 16-bit lane word, which carries two RAW8 pixels.
  typedef logic [15:0] lane_data_t;

  // 24-bit RGB pixel as it arrives on rgb_in: R=[23:16], G=[15:8], B=[7:0].
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_pix_t;

  typedef enum logic [1:0] {
    RGB2RAW_IDLE      = 2'd0,
    RGB2RAW_WAIT_ODD  = 2'd1,
    RGB2RAW_WAIT_EVEN = 2'd2
  } rgb2raw_state_e;

endpackage

// File: rtl/rgb2raw.sv
// rtl/rgb2raw.sv - Bayer mosaicing encoder: RGB pixel pairs to RAW8 lane words
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   rgb_in/rgb_valid/sof      input pixel stream, sof marks pixel 0 of a frame
//   rgb_ready                 pixel accepted when rgb_valid & rgb_ready
//   data_out/data_valid       output word {G,B} on even lines, {R,G} on odd lines
//   data_ready                word consumed when data_valid & data_ready
//   line_end/frame_end        sideband flags travelling with data_out
//   err_sticky                sof seen mid-frame, cleared only by rst
//
// Build option: define RGB2RAW_CRUVI_INV_EN to bit-invert R and G on input.
module rgb2raw
  import top_pkg::*;
#(
  parameter int LINE_LENGTH = 640,
  parameter int FRAME_LINES = 480,
  parameter int RGB_WIDTH   = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [RGB_WIDTH-1:0] rgb_in,
  input  logic                 rgb_valid,
  input  logic                 sof,
  output logic                 rgb_ready,
  output lane_data_t           data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 line_end,
  output logic                 frame_end,
  output logic                 err_sticky
);

  localparam int PIX_W  = (LINE_LENGTH > 1) ? $clog2(LINE_LENGTH) : 1;
  localparam int LINE_W = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;

  rgb2raw_state_e    state_q, state_d;
  logic [PIX_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic [LINE_W-1:0] line_cnt_q, line_cnt_d;
  logic [7:0]        hold_q, hold_d;
  lane_data_t        data_q, data_d;
  logic              valid_q, valid_d;
  logic              le_q, le_d;
  logic              fe_q, fe_d;
  logic              err_q, err_d;

  rgb_pix_t pix;
  logic     accept, drain, last_pix, last_line, at_frame_start;
  logic [7:0] first_byte, second_byte;

  // CRUVI A drives R and G inverted; undo it here so loopback stays bit-exact.
  always_comb begin
    pix = rgb_in[23:0];
`ifdef RGB2RAW_CRUVI_INV_EN
    pix.r = ~pix.r;
    pix.g = ~pix.g;
`endif
  end

  // A pending word can be replaced only if it is drained in the same cycle.
  assign rgb_ready = (state_q == RGB2RAW_WAIT_ODD) ? (~valid_q | data_ready) : 1'b1;
  assign accept    = rgb_valid & rgb_ready;
  assign drain     = valid_q & data_ready;

  assign last_pix  = (pix_cnt_q == PIX_W'(LINE_LENGTH - 1));
  assign last_line = (line_cnt_q == LINE_W'(FRAME_LINES - 1));
  // Only WAIT_EVEN at word 0 of line 0 is a clean frame boundary; in practice the
  // last word sends the FSM to IDLE, so this mostly guards a reparameterised build.
  assign at_frame_start = (state_q == RGB2RAW_WAIT_EVEN) && (pix_cnt_q == '0) && (line_cnt_q == '0);

  // Even lines carry G/B, odd lines R/G.
  assign first_byte  = line_cnt_q[0] ? pix.r : pix.g;
  assign second_byte = line_cnt_q[0] ? pix.g : pix.b;

  always_comb begin
    state_d    = state_q;
    pix_cnt_d  = pix_cnt_q;
    line_cnt_d = line_cnt_q;
    hold_d     = hold_q;
    data_d     = data_q;
    valid_d    = valid_q;
    le_d       = le_q;
    fe_d       = fe_q;
    err_d      = err_q;

    if (drain) valid_d = 1'b0;

    if (accept) begin
      if (sof) begin
        // Resynchronise on any sof; the pending output word is left alone.
        if (state_q != RGB2RAW_IDLE && !at_frame_start) err_d = 1'b1;
        hold_d     = pix.g;
        pix_cnt_d  = '0;
        line_cnt_d = '0;
        state_d    = RGB2RAW_WAIT_ODD;
      end else begin
        case (state_q)
          RGB2RAW_WAIT_EVEN: begin
            hold_d  = first_byte;
            state_d = RGB2RAW_WAIT_ODD;
          end
          RGB2RAW_WAIT_ODD: begin
            data_d  = {hold_q, second_byte};
            valid_d = 1'b1;
            le_d    = last_pix;
            fe_d    = last_pix & last_line;
            if (last_pix) begin
              pix_cnt_d  = '0;
              line_cnt_d = last_line ? '0 : line_cnt_q + 1'b1;
            end else begin
              pix_cnt_d = pix_cnt_q + 1'b1;
            end
            state_d = (last_pix && last_line) ? RGB2RAW_IDLE : RGB2RAW_WAIT_EVEN;
          end
          default: ;  // IDLE drops pixels until sof
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RGB2RAW_IDLE;
      pix_cnt_q  <= '0;
      line_cnt_q <= '0;
      hold_q     <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      le_q       <= 1'b0;
      fe_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pix_cnt_q  <= pix_cnt_d;
      line_cnt_q <= line_cnt_d;
      hold_q     <= hold_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      le_q       <= le_d;
      fe_q       <= fe_d;
      err_q      <= err_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign line_end   = le_q;
  assign frame_end  = fe_q;
  assign err_sticky = err_q;

endmodule

// File: tb/tb_rgb2raw.sv
// tb/tb_rgb2raw.sv - directed table-driven bench for rgb2raw (LINE_LENGTH=4, FRAME_LINES=2)
module tb_rgb2raw;
  import top_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] rgb_in = '0;
  logic        rgb_valid = 1'b0;
  logic        sof = 1'b0;
  logic        rgb_ready;
  lane_data_t  data_out;
  logic        data_valid;
  logic        data_ready = 1'b1;
  logic        line_end, frame_end, err_sticky;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  rgb2raw #(.LINE_LENGTH(4), .FRAME_LINES(2), .RGB_WIDTH(24)) dut (
    .clk(clk), .rst(rst), .rgb_in(rgb_in), .rgb_valid(rgb_valid), .sof(sof),
    .rgb_ready(rgb_ready), .data_out(data_out), .data_valid(data_valid),
    .data_ready(data_ready), .line_end(line_end), .frame_end(frame_end),
    .err_sticky(err_sticky)
  );

  typedef struct {
    logic        s;
    logic [23:0] p0;
    logic [23:0] p1;
    logic [15:0] word;
    logic        le;
    logic        fe;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; rgb_valid = 1'b0; sof = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Offer one pixel and return 1 time unit after the edge that accepted it.
  task automatic push(input logic s, input logic [23:0] p);
    int n = 0;
    @(negedge clk);
    rgb_in = p; sof = s; rgb_valid = 1'b1;
    while (!rgb_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rgb_ready) chk("push_timeout", 32'(rgb_ready), 32'd1);
    @(posedge clk);
    #1;
    rgb_valid = 1'b0; sof = 1'b0;
  endtask

  task automatic push_pair_chk(input string name, input logic s, input logic [23:0] p0,
                               input logic [23:0] p1, input logic [15:0] w,
                               input logic le, input logic fe);
    push(s, p0);
    push(1'b0, p1);
    chk({name, "_valid"}, 32'(data_valid), 32'd1);
    chk({name, "_data"}, 32'(data_out), 32'(w));
    chk({name, "_le"}, 32'(line_end), 32'(le));
    chk({name, "_fe"}, 32'(frame_end), 32'(fe));
  endtask

  initial begin
    vecs[0] = '{1'b1, 24'h112233, 24'h445566, 16'h2266, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 24'h010203, 24'h040506, 16'h0206, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 24'h0A0B0C, 24'h0D0E0F, 16'h0B0F, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 24'h102030, 24'h405060, 16'h2060, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 24'hAABBCC, 24'hDDEEFF, 16'hAAEE, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 24'h111111, 24'h222222, 16'h1122, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 24'h123456, 24'h789ABC, 16'h129A, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 24'hFEDCBA, 24'h987654, 16'hFE76, 1'b1, 1'b1};

    // Reset state
    @(posedge clk); @(posedge clk);
    #1;
    chk("rst_valid", 32'(data_valid), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_le", 32'(line_end), 32'd0);
    chk("rst_fe", 32'(frame_end), 32'd0);
    chk("rst_err", 32'(err_sticky), 32'd0);
    chk("rst_ready", 32'(rgb_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

`ifdef RGB2RAW_CRUVI_INV_EN
    push_pair_chk("inv_w0", 1'b1, 24'h000000, 24'h000000, 16'hFF00, 1'b0, 1'b0);
`else
    // Full frame: 16 pixels -> 8 words
    for (int i = 0; i < 8; i++)
      push_pair_chk($sformatf("frame_w%0d", i), vecs[i].s, vecs[i].p0, vecs[i].p1,
                    vecs[i].word, vecs[i].le, vecs[i].fe);
    chk("frame_state_idle", 32'(dut.state_q), 32'(RGB2RAW_IDLE));
    // Pixels without sof after the frame are dropped silently
    push(1'b0, 24'h999999);
    push(1'b0, 24'h888888);
    chk("idle_drop_valid", 32'(data_valid), 32'd0);
    chk("idle_drop_err", 32'(err_sticky), 32'd0);

    // Backpressure: word held while the sink stalls, then drain+load without a bubble
    do_reset();
    data_ready = 1'b0;
    push(1'b1, 24'h112233);
    push(1'b0, 24'h445566);
    chk("stall_w0", 32'(data_out), 32'h2266);
    push(1'b0, 24'h010203);
    @(negedge clk);
    rgb_in = 24'h040506; rgb_valid = 1'b1; sof = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("stall_ready_%0d", i), 32'(rgb_ready), 32'd0);
      chk($sformatf("stall_data_%0d", i), 32'(data_out), 32'h2266);
      chk($sformatf("stall_valid_%0d", i), 32'(data_valid), 32'd1);
    end
    data_ready = 1'b1;
    @(posedge clk);
    #1;
    rgb_valid = 1'b0;
    chk("stall_w1_valid", 32'(data_valid), 32'd1);
    chk("stall_w1_data", 32'(data_out), 32'h0206);
    @(posedge clk);
    #1;
    chk("stall_drained", 32'(data_valid), 32'd0);
    chk("stall_err", 32'(err_sticky), 32'd0);

    // sof mid-frame: error, half word discarded, counters restart
    do_reset();
    push_pair_chk("sof_w0", 1'b1, 24'h010101, 24'h020202, 16'h0102, 1'b0, 1'b0);
    push(1'b0, 24'h030303);
    push_pair_chk("sof_resync", 1'b1, 24'hA0A1A2, 24'hB0B1B2, 16'hA1B2, 1'b0, 1'b0);
    chk("sof_err", 32'(err_sticky), 32'd1);
    push_pair_chk("sof_w1", 1'b0, 24'h111111, 24'h222222, 16'h1122, 1'b0, 1'b0);
    push_pair_chk("sof_w2", 1'b0, 24'h333333, 24'h444444, 16'h3344, 1'b0, 1'b0);
    push_pair_chk("sof_w3", 1'b0, 24'h555555, 24'h666666, 16'h5566, 1'b1, 1'b0);
    chk("sof_err_sticks", 32'(err_sticky), 32'd1);

    // Reset mid-frame clears the error and requires a new sof
    push(1'b0, 24'h777777);
    do_reset();
    chk("rst2_err", 32'(err_sticky), 32'd0);
    chk("rst2_valid", 32'(data_valid), 32'd0);
    push(1'b0, 24'h121212);
    push(1'b0, 24'h343434);
    chk("rst2_no_word", 32'(data_valid), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
